pwm_burst_sequencer: RTL and testbench

- Upstream controller for half_pwm_die.
- Holds a small table of pulse descriptors: pulse period, dead-time period, default level and inter-pulse gap.
- On a start command it walks the table, optionally for several passes. For each entry it drives the downstream config, issues a one-cycle io_en strobe, waits for the downstream pulse_valid, then counts out the gap.
- Provides abort and a completion watchdog; both drive pwm_dis.

---
 rtl/pwm_pkg.sv | 25 ++
 rtl/pwm_seq_table.sv | 30 +++
 rtl/pwm_burst_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pwm_burst_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared state encodings and descriptor record for the PWM burst sequencer.
// Latency: none, types and constants only.
// Backpressure: none.
package pwm_pkg;

    // Default width of the period, dead-time and gap fields.
    localparam int unsigned PWM_RAM_WIDTH = 32;

    // Sequencer states, kept as plain constants so legacy code can share the encoding.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_LOAD      = 3'd1;
    localparam state_t S_FIRE      = 3'd2;
    localparam state_t S_WAIT_DONE = 3'd3;
    localparam state_t S_GAP       = 3'd4;

    // One pulse descriptor as held in the table.
    typedef struct packed {
        logic [PWM_RAM_WIDTH-1:0] pulse_period;
        logic [PWM_RAM_WIDTH-1:0] die_period;
        logic [PWM_RAM_WIDTH-1:0] gap;
        logic                     level;
    } desc_t;

endpackage

// File: rtl/pwm_seq_table.sv
// Descriptor register file: DEPTH entries, synchronous write, asynchronous read.
// Latency: write visible the cycle after wr_vld; read is combinational.
// Backpressure: none; writes arriving while idle is low are dropped.
module pwm_seq_table
    import pwm_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          io_clk,
    input  logic          idle,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  desc_t         wr_dat,
    input  logic [AW-1:0] rd_addr,
    output desc_t         rd_dat
);

    desc_t mem [DEPTH];

    // Accept table writes only while the sequencer is idle so a running burst never sees a change.
    always_ff @(posedge io_clk) begin
        if (wr_vld && idle) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/pwm_burst_sequencer.sv
// Walks a descriptor table, driving half_pwm_die config plus an io_en strobe per entry, for N passes.
// Latency: seq_start at edge N -> config valid after N+1 -> io_en high between N+2 and N+3.
// Backpressure: waits on the pulse_valid rising edge per entry; abort or watchdog pulse pwm_dis.
module pwm_burst_sequencer
    import pwm_pkg::*;
#(
    parameter int unsigned _RAM_WIDTH     = PWM_RAM_WIDTH,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned AW             = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  io_clk,
    input  logic                  io_rst_n,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic [_RAM_WIDTH-1:0] cfg_pulse_period,
    input  logic [_RAM_WIDTH-1:0] cfg_die_period,
    input  logic [_RAM_WIDTH-1:0] cfg_gap,
    input  logic                  cfg_level,
    input  logic [AW:0]           seq_len,
    input  logic [15:0]           seq_repeat,
    input  logic                  seq_start,
    input  logic                  seq_abort,
    input  logic                  pulse_valid,
    output logic [_RAM_WIDTH-1:0] pulse_period,
    output logic [_RAM_WIDTH-1:0] die_period,
    output logic                  io_defaultLevel,
    output logic                  io_en,
    output logic                  pwm_dis,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  err_timeout,
    output logic [AW-1:0]         cur_idx
);

    localparam int unsigned   W        = _RAM_WIDTH;
    localparam logic [W-1:0]  TO_LIMIT = W'(TIMEOUT_CYCLES);
    localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};

    state_t        state;
    logic [AW-1:0] idx;
    logic [15:0]   pass;
    logic [AW:0]   len_q;
    logic [15:0]   rep_q;
    logic [W-1:0]  gap_cnt;
    logic [W-1:0]  to_cnt;
    logic [W-1:0]  to_next;
    logic [W-1:0]  cur_gap;
    logic          pv_q;
    logic          pv_rise;
    logic          is_idle;
    logic          last_idx;
    logic          last_pass;
    logic          to_fire;
    logic [AW-1:0] idx_adv;
    logic [15:0]   pass_adv;
    desc_t         tbl_wr;
    desc_t         tbl_rd;

    // The descriptor record width follows the package; narrower or wider buses are cast at the boundary.
    assign tbl_wr.pulse_period = PWM_RAM_WIDTH'(cfg_pulse_period);
    assign tbl_wr.die_period   = PWM_RAM_WIDTH'(cfg_die_period);
    assign tbl_wr.gap          = PWM_RAM_WIDTH'(cfg_gap);
    assign tbl_wr.level        = cfg_level;

    pwm_seq_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .io_clk  (io_clk),
        .idle    (is_idle),
        .wr_vld  (cfg_we),
        .wr_addr (cfg_addr),
        .wr_dat  (tbl_wr),
        .rd_addr (idx),
        .rd_dat  (tbl_rd)
    );

    assign is_idle   = (state == S_IDLE);
    assign busy      = ~is_idle;
    assign pv_rise   = pulse_valid & ~pv_q;
    assign last_idx  = ({1'b0, idx} == (len_q - LEN_ONE));
    assign last_pass = (rep_q != 16'd0) && (pass == (rep_q - 16'd1));
    assign idx_adv   = last_idx ? '0 : (idx + AW'(1));
    assign pass_adv  = last_idx ? (pass + 16'd1) : pass;
    assign cur_gap   = W'(tbl_rd.gap);
    // Watchdog counter saturates instead of wrapping.
    assign to_next   = (to_cnt == '1) ? to_cnt : (to_cnt + W'(1));
    assign to_fire   = (TIMEOUT_CYCLES != 0) && (to_next == TO_LIMIT);

    // Sequencer FSM: abort first, then per-state progress; strobes default low every cycle.
    always_ff @(posedge io_clk or negedge io_rst_n) begin
        if (!io_rst_n) begin
            state           <= S_IDLE;
            idx             <= '0;
            pass            <= '0;
            len_q           <= '0;
            rep_q           <= '0;
            gap_cnt         <= '0;
            to_cnt          <= '0;
            pv_q            <= 1'b0;
            pulse_period    <= '0;
            die_period      <= '0;
            io_defaultLevel <= 1'b0;
            io_en           <= 1'b0;
            pwm_dis         <= 1'b0;
            seq_done        <= 1'b0;
            err_timeout     <= 1'b0;
            cur_idx         <= '0;
        end else begin
            io_en    <= 1'b0;
            pwm_dis  <= 1'b0;
            seq_done <= 1'b0;
            pv_q     <= pulse_valid;
            if (!is_idle && seq_abort) begin
                pwm_dis <= 1'b1;
                state   <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (seq_start) begin
                            if (seq_len != '0) begin
                                len_q       <= seq_len;
                                rep_q       <= seq_repeat;
                                idx         <= '0;
                                pass        <= '0;
                                err_timeout <= 1'b0;
                                state       <= S_LOAD;
                            end else begin
                                seq_done <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        pulse_period    <= W'(tbl_rd.pulse_period);
                        die_period      <= W'(tbl_rd.die_period);
                        io_defaultLevel <= tbl_rd.level;
                        cur_idx         <= idx;
                        state           <= S_FIRE;
                    end
                    S_FIRE: begin
                        io_en  <= 1'b1;
                        to_cnt <= '0;
                        state  <= S_WAIT_DONE;
                    end
                    S_WAIT_DONE: begin
                        to_cnt <= to_next;
                        if (pv_rise) begin
                            if (last_idx && last_pass) begin
                                seq_done <= 1'b1;
                                state    <= S_IDLE;
                            end else if (cur_gap == '0) begin
                                idx   <= idx_adv;
                                pass  <= pass_adv;
                                state <= S_LOAD;
                            end else begin
                                gap_cnt <= cur_gap - W'(1);
                                state   <= S_GAP;
                            end
                        end else if (to_fire) begin
                            err_timeout <= 1'b1;
                            pwm_dis     <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end
                    S_GAP: begin
                        if (gap_cnt == '0) begin
                            idx   <= idx_adv;
                            pass  <= pass_adv;
                            state <= S_LOAD;
                        end else begin
                            gap_cnt <= gap_cnt - W'(1);
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_burst_sequencer.sv
// Directed bench for pwm_burst_sequencer with hand-computed expectations.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled at the same point.
// Backpressure: bench plays the half_pwm_die side by pulsing pulse_valid after each io_en.
module tb_pwm_burst_sequencer;

    logic        io_clk = 1'b0;
    logic        io_rst_n = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_pulse_period = '0;
    logic [31:0] cfg_die_period = '0;
    logic [31:0] cfg_gap = '0;
    logic        cfg_level = 1'b0;
    logic [3:0]  seq_len = '0;
    logic [15:0] seq_repeat = '0;
    logic        seq_start = 1'b0;
    logic        seq_abort = 1'b0;
    logic        pulse_valid = 1'b0;
    logic [31:0] pulse_period;
    logic [31:0] die_period;
    logic        io_defaultLevel;
    logic        io_en;
    logic        pwm_dis;
    logic        busy;
    logic        seq_done;
    logic        err_timeout;
    logic [2:0]  cur_idx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int en_cnt = 0;
    int sd_cnt = 0;
    int t_rise = 0;

    pwm_burst_sequencer #(
        ._RAM_WIDTH     (32),
        .DEPTH          (8),
        .AW             (3),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .io_clk           (io_clk),
        .io_rst_n         (io_rst_n),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_pulse_period (cfg_pulse_period),
        .cfg_die_period   (cfg_die_period),
        .cfg_gap          (cfg_gap),
        .cfg_level        (cfg_level),
        .seq_len          (seq_len),
        .seq_repeat       (seq_repeat),
        .seq_start        (seq_start),
        .seq_abort        (seq_abort),
        .pulse_valid      (pulse_valid),
        .pulse_period     (pulse_period),
        .die_period       (die_period),
        .io_defaultLevel  (io_defaultLevel),
        .io_en            (io_en),
        .pwm_dis          (pwm_dis),
        .busy             (busy),
        .seq_done         (seq_done),
        .err_timeout      (err_timeout),
        .cur_idx          (cur_idx)
    );

    always #5 io_clk = ~io_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and sample outputs 1 ns later.
    task automatic tick();
        @(posedge io_clk);
        #1;
        cyc++;
        if (io_en) en_cnt++;
        if (seq_done) sd_cnt++;
    endtask

    task automatic wr_entry(input int addr, input int pp, input int dp, input int gp, input bit lvl);
        cfg_addr         = 3'(addr);
        cfg_pulse_period = 32'(pp);
        cfg_die_period   = 32'(dp);
        cfg_gap          = 32'(gp);
        cfg_level        = lvl;
        cfg_we           = 1'b1;
        tick();
        cfg_we           = 1'b0;
    endtask

    task automatic start_seq(input int len, input int rep);
        seq_len    = 4'(len);
        seq_repeat = 16'(rep);
        seq_start  = 1'b1;
        tick();
        seq_start  = 1'b0;
    endtask

    // Play the downstream side: two cycles of work, then a one-cycle pulse_valid.
    task automatic respond();
        tick();
        tick();
        pulse_valid = 1'b1;
        t_rise = cyc + 1;
        tick();
        pulse_valid = 1'b0;
    endtask

    // Wait for io_en (want_dis=0) or pwm_dis (want_dis=1), bounded.
    task automatic wait_for(input bit want_dis, input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound && !ok; k++) begin
            tick();
            if (want_dis ? pwm_dis : io_en) ok = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        bit ok;
        int en0;
        int sd0;
        int n0;
        int pp [3];
        int gp [3];
        pp = '{20, 30, 40};
        gp = '{10, 0, 4};

        #2 io_rst_n = 1'b0;
        repeat (3) @(posedge io_clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_io_en", 32'(io_en), 0);
        chk("rst_pwm_dis", 32'(pwm_dis), 0);
        chk("rst_seq_done", 32'(seq_done), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_period", pulse_period, 0);
        chk("rst_level", 32'(io_defaultLevel), 0);
        io_rst_n = 1'b1;
        tick();

        // Single entry, single pass: latency and one-cycle io_en.
        wr_entry(0, 5, 3, 0, 1'b0);
        start_seq(1, 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_en_early", 32'(io_en), 0);
        tick();
        chk("t1_period", pulse_period, 5);
        chk("t1_die", die_period, 3);
        chk("t1_level", 32'(io_defaultLevel), 0);
        chk("t1_en_n1", 32'(io_en), 0);
        tick();
        chk("t1_en_n2", 32'(io_en), 1);
        tick();
        chk("t1_en_n3", 32'(io_en), 0);
        pulse_valid = 1'b1;
        tick();
        pulse_valid = 1'b0;
        chk("t1_done", 32'(seq_done), 1);
        chk("t1_idle", 32'(busy), 0);
        tick();
        chk("t1_done_clr", 32'(seq_done), 0);

        // Three entries, two passes, gaps 10/0/4; a write while busy must be dropped.
        wr_entry(0, 20, 2, 10, 1'b1);
        wr_entry(1, 30, 4, 0, 1'b0);
        wr_entry(2, 40, 6, 4, 1'b1);
        en0 = en_cnt;
        sd0 = sd_cnt;
        start_seq(3, 2);
        for (int i = 0; i < 6; i++) begin
            wait_for(1'b0, 60, ok);
            chk("t2_en_seen", 32'(ok), 1);
            chk("t2_idx", 32'(cur_idx), i % 3);
            chk("t2_period", pulse_period, pp[i % 3]);
            chk("t2_level", 32'(io_defaultLevel), ((i % 3) == 1) ? 0 : 1);
            if (i > 0) chk("t2_gap", cyc - t_rise - 2, gp[(i - 1) % 3]);
            if (i == 0) wr_entry(1, 999, 4, 0, 1'b0);
            respond();
        end
        repeat (3) tick();
        chk("t2_en_count", en_cnt - en0, 6);
        chk("t2_done_count", sd_cnt - sd0, 1);
        chk("t2_idle", 32'(busy), 0);

        // Abort during the gap after entry 1.
        wr_entry(0, 20, 2, 0, 1'b1);
        wr_entry(1, 30, 4, 8, 1'b0);
        en0 = en_cnt;
        sd0 = sd_cnt;
        start_seq(3, 1);
        wait_for(1'b0, 20, ok);
        respond();
        wait_for(1'b0, 20, ok);
        chk("t3_idx1", 32'(cur_idx), 1);
        respond();
        tick();
        tick();
        seq_abort = 1'b1;
        tick();
        seq_abort = 1'b0;
        chk("t3_dis", 32'(pwm_dis), 1);
        chk("t3_idle", 32'(busy), 0);
        tick();
        chk("t3_dis_clr", 32'(pwm_dis), 0);
        chk("t3_hold_period", pulse_period, 30);
        chk("t3_hold_die", die_period, 4);
        chk("t3_hold_idx", 32'(cur_idx), 1);
        repeat (20) tick();
        chk("t3_en_count", en_cnt - en0, 2);
        chk("t3_no_done", sd_cnt - sd0, 0);

        // Watchdog: no pulse_valid, fires after 50 WAIT_DONE cycles.
        sd0 = sd_cnt;
        start_seq(1, 1);
        n0 = cyc;
        wait_for(1'b1, 80, ok);
        chk("t4_dis_seen", 32'(ok), 1);
        chk("t4_fire_cycle", cyc - n0, 52);
        chk("t4_err", 32'(err_timeout), 1);
        chk("t4_idle", 32'(busy), 0);
        repeat (10) tick();
        chk("t4_err_sticky", 32'(err_timeout), 1);
        chk("t4_dis_clr", 32'(pwm_dis), 0);
        chk("t4_no_done", sd_cnt - sd0, 0);
        start_seq(1, 1);
        chk("t4_err_cleared", 32'(err_timeout), 0);

        // Reset in the middle of WAIT_DONE clears outputs without a clock edge.
        tick();
        tick();
        tick();
        chk("t7_busy_before", 32'(busy), 1);
        io_rst_n = 1'b0;
        #1;
        chk("t7_busy", 32'(busy), 0);
        chk("t7_period", pulse_period, 0);
        chk("t7_die", die_period, 0);
        chk("t7_level", 32'(io_defaultLevel), 0);
        tick();
        io_rst_n = 1'b1;
        tick();

        // Zero-length start: seq_done one cycle later, no io_en.
        en0 = en_cnt;
        sd0 = sd_cnt;
        start_seq(0, 1);
        chk("t6_done", 32'(seq_done), 1);
        chk("t6_idle", 32'(busy), 0);
        tick();
        chk("t6_done_clr", 32'(seq_done), 0);
        repeat (5) tick();
        chk("t6_no_en", en_cnt - en0, 0);
        chk("t6_done_count", sd_cnt - sd0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
